// File: rtl/mem_arbiter.sv
// Shares one single-port memory between fetch and load/store; load/store wins unless fetch is starved.
// Latency: request -> *_ready next cycle -> *_valid/data the cycle after; requesters hold until *_ready.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [11:0] if_addr,
  output logic        if_ready,
  output logic        if_valid,
  output logic [31:0] if_rdata,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [3:0]  ls_mask,
  input  logic [11:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_ready,
  output logic        ls_valid,
  output logic [31:0] ls_rdata,
  output logic        mem_request,
  output logic        mem_we_re,
  output logic [3:0]  mem_mask,
  output logic [11:0] mem_address,
  output logic [31:0] mem_data_in,
  input  logic        mem_valid,
  input  logic [31:0] mem_data_out
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_e      state_q, state_d;
  logic [3:0]  starve_q, starve_d;
  logic        own_ls_q, own_ls_d;
  logic        we_q, we_d;
  logic [3:0]  mask_q, mask_d;
  logic [11:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic grant_ls;
  logic grant_if;
  logic unused_mem_valid;

  // The memory's valid never drops, so completion is timed by the FSM alone.
  assign unused_mem_valid = mem_valid;

  assign grant_ls = ls_req && !(if_req && (starve_q == LIMIT));
  assign grant_if = if_req && !grant_ls;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      starve_q <= '0;
      own_ls_q <= 1'b0;
      we_q     <= 1'b0;
      mask_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      own_ls_q <= own_ls_d;
      we_q     <= we_d;
      mask_q   <= mask_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    own_ls_d = own_ls_q;
    we_d     = we_q;
    mask_d   = mask_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    case (state_q)
      ISSUE: state_d = RESP;
      default: begin
        if (grant_ls) begin
          state_d  = ISSUE;
          own_ls_d = 1'b1;
          we_d     = ls_we;
          mask_d   = ls_mask;
          addr_d   = ls_addr;
          wdata_d  = ls_wdata;
          // Only grants that make fetch wait count towards starvation.
          if (if_req) begin
            starve_d = (starve_q >= LIMIT) ? LIMIT : starve_q + 4'd1;
          end else begin
            starve_d = '0;
          end
        end else if (grant_if) begin
          state_d  = ISSUE;
          own_ls_d = 1'b0;
          we_d     = 1'b0;
          mask_d   = '0;
          addr_d   = if_addr;
          wdata_d  = '0;
          starve_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_comb begin
    if_ready    = 1'b0;
    ls_ready    = 1'b0;
    if_valid    = 1'b0;
    ls_valid    = 1'b0;
    mem_request = 1'b0;
    mem_we_re   = 1'b0;
    mem_mask    = '0;
    mem_address = '0;
    mem_data_in = '0;
    case (state_q)
      ISSUE: begin
        mem_request = 1'b1;
        mem_we_re   = we_q;
        mem_mask    = mask_q;
        mem_address = addr_q;
        mem_data_in = wdata_q;
        if_ready    = !own_ls_q;
        ls_ready    = own_ls_q;
      end
      RESP: begin
        if_valid = !own_ls_q;
        ls_valid = own_ls_q;
      end
      default: ;
    endcase
  end

  assign if_rdata = mem_data_out;
  assign ls_rdata = mem_data_out;

endmodule
